mariam_updown_sched: RTL

- Two-requester scheduler/arbiter that shares one up/down counter datapath.
- Each requester asks for a burst of N single steps in one direction. The block grants round-robin, sequences the steps one per clock, and pulses done to the owner.
- Sits between user-area control logic and the counter whose value drives the io pins.

---
 rtl/mariam_updown_pkg.sv | 23 ++
 rtl/mariam_updown_step_counter.sv | 44 ++++
 rtl/mariam_updown_sched.sv | 130 +++++++++++++
 3 files changed

// File: rtl/mariam_updown_pkg.sv
// Shared types and constants for the two-requester up/down counter scheduler.
package mariam_updown_pkg;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_RUN  = 2'd1,
      ST_DONE = 2'd2
   } state_e;

   localparam int   NREQ     = 2;
   localparam logic DIR_UP   = 1'b0;
   localparam logic DIR_DOWN = 1'b1;

   // Round-robin pick between two requesters. On a tie the one that was not
   // granted last wins; a lone requester always wins.
   function automatic logic rr_pick(input logic [1:0] req, input logic last);
      if (req == 2'b11) begin
         return ~last;
      end
      return req[1];
   endfunction

endpackage

// File: rtl/mariam_updown_step_counter.sv
// Wrapping up/down counter advanced one step per enabled cycle; clear wins over a step.
module mariam_updown_step_counter
   import mariam_updown_pkg::*;
#(
   parameter int WIDTH = 4
)
(
   input  logic             clk,
   input  logic             reset_n,
   input  logic             en,
   input  logic             dir,
   input  logic             clr,
   output logic [WIDTH-1:0] value
);

   logic [WIDTH-1:0] value_q;
   logic [WIDTH-1:0] value_d;

   // Next value: clear, single step up/down (modulo 2^WIDTH), or hold.
   always_comb begin
      value_d = value_q;
      if (clr) begin
         value_d = '0;
      end else if (en) begin
         case (dir)
            DIR_UP:   value_d = value_q + WIDTH'(1);
            DIR_DOWN: value_d = value_q - WIDTH'(1);
            default:  value_d = value_q;
         endcase
      end
   end

   // Counter register.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         value_q <= '0;
      end else begin
         value_q <= value_d;
      end
   end

   assign value = value_q;

endmodule

// File: rtl/mariam_updown_sched.sv
// Round-robin scheduler granting one of two requesters a burst of single
// up/down steps on a shared counter, with abort on request drop.
module mariam_updown_sched
   import mariam_updown_pkg::*;
#(
   parameter int WIDTH = 4,
   parameter int LEN_W = 4
)
(
   input  logic             clk,
   input  logic             reset_n,
   input  logic [1:0]       req,
   input  logic [1:0]       dir,
   input  logic [LEN_W-1:0] len0,
   input  logic [LEN_W-1:0] len1,
   input  logic             clr,
   output logic [1:0]       gnt,
   output logic [1:0]       done,
   output logic             busy,
   output logic [WIDTH-1:0] counter,
   output logic [WIDTH-1:0] io_oeb
);

   state_e            state_q, state_d;
   logic [NREQ-1:0]   gnt_q, gnt_d;
   logic [NREQ-1:0]   done_q, done_d;
   logic              owner_q, owner_d;
   logic              last_q, last_d;
   logic              dir_q, dir_d;
   logic [LEN_W-1:0]  rem_q, rem_d;
   logic              step_en;
   logic              cnt_clr;
   logic              winner;

   assign winner = rr_pick(req, last_q);

   // FSM next state, arbitration, burst latching and step sequencing.
   always_comb begin
      state_d = state_q;
      gnt_d   = gnt_q;
      done_d  = '0;
      owner_d = owner_q;
      last_d  = last_q;
      dir_d   = dir_q;
      rem_d   = rem_q;
      step_en = 1'b0;
      cnt_clr = 1'b0;
      case (state_q)
         ST_IDLE: begin
            gnt_d = '0;
            if (clr) begin
               // Clear beats any pending request; arbitration waits a cycle.
               cnt_clr = 1'b1;
            end else if (|req) begin
               owner_d        = winner;
               last_d         = winner;
               dir_d          = dir[winner];
               rem_d          = winner ? len1 : len0;
               gnt_d[winner]  = 1'b1;
               state_d        = ST_RUN;
            end
         end
         ST_RUN: begin
            if (!req[owner_q]) begin
               // Abort: steps already taken stay, no completion pulse.
               state_d = ST_IDLE;
               gnt_d   = '0;
            end else if (rem_q == '0) begin
               // Zero-length burst completes without touching the counter.
               state_d         = ST_DONE;
               done_d[owner_q] = 1'b1;
            end else begin
               step_en = 1'b1;
               rem_d   = rem_q - LEN_W'(1);
               // Raise done together with the last step so both land in the same cycle.
               if (rem_q == LEN_W'(1)) begin
                  state_d         = ST_DONE;
                  done_d[owner_q] = 1'b1;
               end
            end
         end
         ST_DONE: begin
            state_d = ST_IDLE;
            gnt_d   = '0;
         end
         default: begin
            state_d = ST_IDLE;
            gnt_d   = '0;
         end
      endcase
   end

   // Control and burst-context registers.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q <= ST_IDLE;
         gnt_q   <= '0;
         done_q  <= '0;
         owner_q <= 1'b0;
         last_q  <= 1'b1;
         dir_q   <= DIR_UP;
         rem_q   <= '0;
      end else begin
         state_q <= state_d;
         gnt_q   <= gnt_d;
         done_q  <= done_d;
         owner_q <= owner_d;
         last_q  <= last_d;
         dir_q   <= dir_d;
         rem_q   <= rem_d;
      end
   end

   mariam_updown_step_counter #(
      .WIDTH (WIDTH)
   ) u_step_counter (
      .clk     (clk),
      .reset_n (reset_n),
      .en      (step_en),
      .dir     (dir_q),
      .clr     (cnt_clr),
      .value   (counter)
   );

   assign gnt    = gnt_q;
   assign done   = done_q;
   assign busy   = (state_q != ST_IDLE);
   assign io_oeb = '0;

endmodule
